mips_mem_arbiter: RTL and testbench

- Shares one single-port unified memory between two requesters of the MIPS datapath: instruction fetch (IF) and load/store data (D).
- Sits between the datapath and the memory model. Returns read data, plus a per-requester stall, to each side.
- Data access has priority, with a starvation cap that guarantees fetch progress. A watchdog aborts memory transactions that hang.

---
 rtl/mips_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mips_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mips_mem_arbiter
// Purpose  : Shares a single-port memory between instruction fetch and data
//            access, with data priority, a fetch starvation cap and a watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mips_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_DATA_RUN = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_IF = 2'd1,
        S_BUSY_D  = 2'd2
    } state_t;

    localparam logic [3:0]        c_MAX_RUN    = 4'(MAX_DATA_RUN);
    localparam logic [7:0]        c_WD_LAST    = 8'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] c_ABORT_DATA = DATA_W'(32'hDEADBEEF);

    state_t            r_state;
    logic [3:0]        r_starve_cnt;
    logic [7:0]        r_wd_cnt;

    logic              w_if_elig;
    logic              w_d_elig;
    logic              w_d_wins;
    logic [DATA_W-1:0] w_rdata;

    // A requester is not eligible in its own completion cycle, so a held
    // request is never granted twice for one transaction.
    assign w_if_elig = if_req & ~if_valid;
    assign w_d_elig  = d_req & ~d_valid;
    assign w_d_wins  = w_d_elig & ~(w_if_elig & (r_starve_cnt == c_MAX_RUN));
    assign w_rdata   = mem_ready ? mem_rdata : c_ABORT_DATA;

    assign if_stall  = if_req & ~if_valid;
    assign d_stall   = d_req & ~d_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= 4'd0;
            r_wd_cnt     <= 8'd0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_rdata     <= '0;
            if_valid     <= 1'b0;
            d_rdata      <= '0;
            d_valid      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_wd_cnt <= 8'd0;
                    if (w_d_wins) begin
                        r_state      <= S_BUSY_D;
                        mem_req      <= 1'b1;
                        mem_we       <= d_we;
                        mem_addr     <= d_addr;
                        mem_wdata    <= d_wdata;
                        r_starve_cnt <= w_if_elig ? r_starve_cnt + 4'd1 : 4'd0;
                    end else if (w_if_elig) begin
                        r_state      <= S_BUSY_IF;
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b0;
                        mem_addr     <= if_addr;
                        r_starve_cnt <= 4'd0;
                    end
                end
                S_BUSY_IF, S_BUSY_D: begin
                    // mem_ready takes precedence over a coincident watchdog expiry
                    if (mem_ready || (r_wd_cnt == c_WD_LAST)) begin
                        r_state  <= S_IDLE;
                        mem_req  <= 1'b0;
                        r_wd_cnt <= 8'd0;
                        if (!mem_ready) begin
                            timeout_err <= 1'b1;
                        end
                        if (r_state == S_BUSY_IF) begin
                            if_valid <= 1'b1;
                            if_rdata <= w_rdata;
                        end else begin
                            d_valid <= 1'b1;
                            if (!mem_we) begin
                                d_rdata <= w_rdata;
                            end
                        end
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_mem_arbiter
// Purpose  : Directed self-checking bench for the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    int cnt;
    int guard;

    mips_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_DATA_RUN(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            n_checks++;
            assert (!(if_valid && d_valid)) else begin
                n_errors++;
                $error("FAIL valid_excl: observed %b expected %b", {if_valid, d_valid}, 2'b00);
            end
        end
    end

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_valids", {30'd0, if_valid, d_valid}, 32'd0);
        chk("rst_terr", {31'd0, timeout_err}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        reset = 1'b0;

        // single fetch: cycle 0 request, ready in cycle 2, valid in cycle 3
        if_req = 1'b1; if_addr = 32'h40;
        #1 chk("f_stall_c0", {31'd0, if_stall}, 32'd1);
        tick();
        chk("f_mem_req_c1", {31'd0, mem_req}, 32'd1);
        chk("f_mem_addr", mem_addr, 32'h40);
        chk("f_mem_we", {31'd0, mem_we}, 32'd0);
        chk("f_stall_c1", {31'd0, if_stall}, 32'd1);
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h2002000A;
        #1 chk("f_stall_c2", {31'd0, if_stall}, 32'd1);
        chk("f_valid_c2", {31'd0, if_valid}, 32'd0);
        tick();
        mem_ready = 1'b0;
        chk("f_valid_c3", {31'd0, if_valid}, 32'd1);
        chk("f_rdata", if_rdata, 32'h2002000A);
        chk("f_mem_req_c3", {31'd0, mem_req}, 32'd0);
        chk("f_stall_c3", {31'd0, if_stall}, 32'd0);
        if_req = 1'b0;
        tick();
        chk("f_valid_c4", {31'd0, if_valid}, 32'd0);

        // contention: D served first, IF the cycle after d_valid
        if_req = 1'b1; if_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        tick();
        chk("c_mem_addr_d", mem_addr, 32'h100);
        chk("c_mem_req_d", {31'd0, mem_req}, 32'd1);
        chk("c_stalls", {30'd0, if_stall, d_stall}, 32'd3);
        mem_ready = 1'b1; mem_rdata = 32'h55;
        tick();
        chk("c_d_valid", {31'd0, d_valid}, 32'd1);
        chk("c_d_rdata", d_rdata, 32'h55);
        chk("c_if_valid_0", {31'd0, if_valid}, 32'd0);
        d_req = 1'b0; mem_ready = 1'b0;
        tick();
        chk("c_mem_req_if", {31'd0, mem_req}, 32'd1);
        chk("c_mem_addr_if", mem_addr, 32'h44);
        mem_ready = 1'b1; mem_rdata = 32'h11111111;
        tick();
        chk("c_if_valid", {31'd0, if_valid}, 32'd1);
        chk("c_if_rdata", if_rdata, 32'h11111111);
        if_req = 1'b0; mem_ready = 1'b0;
        tick();

        // starvation cap: 4 D grants with IF pending, then IF, then D again
        for (int i = 0; i < 6; i++) begin
            if_req = 1'b1; if_addr = 32'h80;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300 + 32'(i * 4);
            tick();
            chk("s_mem_req", {31'd0, mem_req}, 32'd1);
            chk("s_grant_addr", mem_addr, (i == 4) ? 32'h80 : 32'h300 + 32'(i * 4));
            mem_ready = 1'b1; mem_rdata = 32'(i);
            tick();
            chk("s_if_valid", {31'd0, if_valid}, (i == 4) ? 32'd1 : 32'd0);
            chk("s_d_valid", {31'd0, d_valid}, (i == 4) ? 32'd0 : 32'd1);
            if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
            tick();
        end

        // mem_ready with no transaction outstanding is ignored
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        chk("idle_ready_ign", {29'd0, if_valid, d_valid, mem_req}, 32'd0);

        // store: write data held, d_rdata keeps last load value (5)
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hCAFEF00D;
        tick();
        chk("st_mem_we", {31'd0, mem_we}, 32'd1);
        chk("st_mem_addr", mem_addr, 32'h200);
        chk("st_mem_wdata", mem_wdata, 32'hCAFEF00D);
        tick();
        chk("st_hold_wdata", mem_wdata, 32'hCAFEF00D);
        chk("st_hold_req", {30'd0, mem_req, mem_we}, 32'd3);
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h12345678;
        tick();
        chk("st_d_valid", {31'd0, d_valid}, 32'd1);
        chk("st_d_rdata", d_rdata, 32'd5);
        d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        tick();

        // timeout on a fetch with mem_ready stuck low
        if_req = 1'b1; if_addr = 32'h500; cnt = 0; guard = 0;
        while (!if_valid && guard < 40) begin
            if (mem_req) cnt++;
            tick();
            guard++;
        end
        chk("to_if_valid", {31'd0, if_valid}, 32'd1);
        chk("to_req_cycles", 32'(cnt), 32'd16);
        chk("to_rdata", if_rdata, 32'hDEADBEEF);
        chk("to_terr", {31'd0, timeout_err}, 32'd1);
        if_req = 1'b0;
        repeat (3) tick();
        chk("to_terr_sticky", {31'd0, timeout_err}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("to_terr_clr", {31'd0, timeout_err}, 32'd0);

        // mem_ready on the final watchdog cycle wins
        if_req = 1'b1; if_addr = 32'h504; cnt = 0; guard = 0;
        while (!if_valid && guard < 40) begin
            if (mem_req) cnt++;
            if (cnt == 16) begin
                mem_ready = 1'b1; mem_rdata = 32'hABCD0123;
            end
            tick();
            guard++;
        end
        mem_ready = 1'b0; if_req = 1'b0;
        chk("tl_if_valid", {31'd0, if_valid}, 32'd1);
        chk("tl_req_cycles", 32'(cnt), 32'd16);
        chk("tl_rdata", if_rdata, 32'hABCD0123);
        chk("tl_terr", {31'd0, timeout_err}, 32'd0);
        tick();

        // reset on the 3rd wait cycle of a load
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
        tick();
        tick();
        tick();
        chk("rb_busy", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        tick();
        chk("rb_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rb_d_valid", {31'd0, d_valid}, 32'd0);
        chk("rb_terr", {31'd0, timeout_err}, 32'd0);
        reset = 1'b0; d_req = 1'b0;
        tick();
        chk("rb_d_valid2", {31'd0, d_valid}, 32'd0);
        if_req = 1'b1; if_addr = 32'h700;
        tick();
        chk("rb_if_grant", {31'd0, mem_req}, 32'd1);
        chk("rb_if_addr", mem_addr, 32'h700);
        mem_ready = 1'b1; mem_rdata = 32'h77;
        tick();
        chk("rb_if_valid", {31'd0, if_valid}, 32'd1);
        chk("rb_if_rdata", if_rdata, 32'h77);
        chk("rb_d_rdata", d_rdata, 32'd0);
        if_req = 1'b0; mem_ready = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
